// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: RV32 base opcodes, ALU op codes
// and the FSM state encoding.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ARITH  = 7'b0010011;
  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;

  // HALT shares its low three bits with IDLE; the halt flag tells them apart on the
  // 3-bit debug port.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_IWAIT  = 4'd2,
    ST_DECODE = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM    = 4'd5,
    ST_MWAIT  = 4'd6,
    ST_WB     = 4'd7,
    ST_HALT   = 4'd8
  } mc_state_e;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_ARITH, OPCODE_R: opcode_legal = 1'b1;
      default:                                           opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch and load/store handshake bundle between the controller (master) and the
// memory side (slave).
interface multicycle_ctrl_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_resp_valid;
  logic lsu_req_valid;
  logic lsu_req_wen;
  logic lsu_req_ready;
  logic lsu_resp_valid;

  modport master (
    output ifu_req_valid, input ifu_req_ready, input ifu_resp_valid,
    output lsu_req_valid, output lsu_req_wen, input lsu_req_ready, input lsu_resp_valid
  );

  modport slave (
    input ifu_req_valid, output ifu_req_ready, output ifu_resp_valid,
    input lsu_req_valid, input lsu_req_wen, output lsu_req_ready, output lsu_resp_valid
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch, decode, execute, memory, writeback, halt.
// Optional response timeout in IWAIT/MWAIT when MULTICYCLE_CTRL_TIMEOUT_EN is defined.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_ctrl_if.master       bus,
  input  logic [6:0]              opcode,
  input  logic                    branch_cond,
  output logic                    ir_we,
  output logic                    rf_we,
  output logic                    pc_we,
  output logic [1:0]              pc_sel,
  output logic                    halt,
  output logic                    illegal,
  output logic                    timeout,
  output logic [2:0]              state
);

  mc_state_e state_q, state_d;
  logic      store_q, store_d;
  logic      illegal_q, illegal_d;
  logic      tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    store_d           = store_q;
    illegal_d         = illegal_q;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    ir_we             = 1'b0;
    rf_we             = 1'b0;
    pc_we             = 1'b0;
    pc_sel            = 2'd0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        bus.ifu_req_valid = 1'b1;
        if (bus.ifu_req_ready && bus.ifu_resp_valid) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (bus.ifu_req_ready) begin
          state_d = ST_IWAIT;
        end
      end
      ST_IWAIT: begin
        if (bus.ifu_resp_valid) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (opcode == OPCODE_SYSTEM) begin
          state_d = ST_HALT;
        end else if (!opcode_legal(opcode)) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Capture store-ness here so MEM never looks at the opcode input.
        store_d = (opcode == OPCODE_STORE);
        state_d = (opcode == OPCODE_LOAD || opcode == OPCODE_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_wen   = store_q;
        if (bus.lsu_req_ready) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (bus.lsu_resp_valid) state_d = ST_WB;
        else if (tmo_hit)       state_d = ST_HALT;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = (opcode != OPCODE_BRANCH) && (opcode != OPCODE_STORE);
        if (opcode == OPCODE_JAL || (opcode == OPCODE_BRANCH && branch_cond)) pc_sel = 2'd1;
        else if (opcode == OPCODE_JALR)                                       pc_sel = 2'd2;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             in_wait;

  assign in_wait = (state_q == ST_IWAIT) || (state_q == ST_MWAIT);
  assign tmo_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (in_wait && state_d == state_q) ? cnt_q + 1'b1 : '0;
      // A response in the final cycle wins; only a real expiry flags timeout.
      if (tmo_hit && state_d == ST_HALT) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign halt    = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign state   = state_q[2:0];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expectations; covers both
// builds of MULTICYCLE_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_cond;
  logic       ir_we, rf_we, pc_we;
  logic [1:0] pc_sel;
  logic       halt, illegal, timeout;
  logic [2:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .opcode      (opcode),
    .branch_cond (branch_cond),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .halt        (halt),
    .illegal     (illegal),
    .timeout     (timeout),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Leaves the controller in FETCH with all handshake inputs low.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.ifu_req_ready = 1'b0; bus.ifu_resp_valid = 1'b0;
    bus.lsu_req_ready = 1'b0; bus.lsu_resp_valid = 1'b0;
    settle();
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({halt, illegal, timeout}), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    settle();
    check("rel_idle", 32'(state), 32'd0);
    cyc();
    check("rel_fetch", 32'(state), 32'd1);
  endtask

  // From FETCH: zero-wait fetch of op, ending in DECODE.
  task automatic fetch_op(input logic [6:0] op);
    opcode = op;
    bus.ifu_req_ready = 1'b1; bus.ifu_resp_valid = 1'b1;
    cyc();
    bus.ifu_req_ready = 1'b0; bus.ifu_resp_valid = 1'b0;
  endtask

  // From FETCH: non-memory op through to WB.
  task automatic run_to_wb(input logic [6:0] op, input logic bc);
    fetch_op(op);
    cyc();
    cyc();
    branch_cond = bc;
    settle();
  endtask

  initial begin
    opcode = 7'd0; branch_cond = 1'b0;
    bus.ifu_req_ready = 1'b0; bus.ifu_resp_valid = 1'b0;
    bus.lsu_req_ready = 1'b0; bus.lsu_resp_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    check("por_outs", 32'({bus.ifu_req_valid, bus.lsu_req_valid, ir_we, rf_we, pc_we, pc_sel}), 32'd0);
    do_reset();

    // ARITH with zero-wait fetch: FETCH(1) DECODE(2) EXEC(3) WB(4) FETCH(5)
    opcode = OPCODE_ARITH;
    bus.ifu_req_ready = 1'b1; bus.ifu_resp_valid = 1'b1;
    settle();
    check("ar_ifu_vld", 32'(bus.ifu_req_valid), 32'd1);
    check("ar_ir_we", 32'(ir_we), 32'd1);
    cyc();
    bus.ifu_req_ready = 1'b0; bus.ifu_resp_valid = 1'b0;
    check("ar_decode", 32'(state), 32'd3);
    check("ar_dec_ir_we", 32'(ir_we), 32'd0);
    cyc();
    check("ar_exec", 32'(state), 32'd4);
    cyc();
    check("ar_wb", 32'(state), 32'd7);
    check("ar_wb_en", 32'({rf_we, pc_we, pc_sel}), 32'b1100);
    cyc();
    check("ar_fetch5", 32'(state), 32'd1);

    // LOAD with split fetch, delayed lsu_req_ready and delayed response
    opcode = OPCODE_LOAD;
    bus.ifu_req_ready = 1'b1;
    settle();
    check("ld_ir_we_nores", 32'(ir_we), 32'd0);
    cyc();
    bus.ifu_req_ready = 1'b0;
    check("ld_iwait", 32'(state), 32'd2);
    check("ld_iwait_vld", 32'({bus.ifu_req_valid, ir_we}), 32'd0);
    bus.ifu_resp_valid = 1'b1;
    settle();
    check("ld_iwait_irwe", 32'(ir_we), 32'd1);
    cyc();
    bus.ifu_resp_valid = 1'b0;
    check("ld_decode", 32'(state), 32'd3);
    cyc(); cyc();
    check("ld_mem", 32'(state), 32'd5);
    for (int i = 0; i < 4; i++) begin
      bus.lsu_req_ready = (i == 3);
      settle();
      check("ld_req_hold", 32'({bus.lsu_req_valid, bus.lsu_req_wen}), 32'b10);
      cyc();
    end
    bus.lsu_req_ready = 1'b0;
    check("ld_mwait", 32'(state), 32'd6);
    check("ld_mwait_vld", 32'(bus.lsu_req_valid), 32'd0);
    bus.ifu_resp_valid = 1'b1;
    cyc();
    bus.ifu_resp_valid = 1'b0;
    check("ld_ign_ifu", 32'({state, ir_we}), 32'({3'd6, 1'b0}));
    bus.lsu_resp_valid = 1'b1;
    cyc();
    bus.lsu_resp_valid = 1'b0;
    check("ld_wb", 32'({state, rf_we, pc_we, pc_sel}), 32'({3'd7, 4'b1100}));
    cyc();

    // Branch taken / not taken, JALR, JAL
    run_to_wb(OPCODE_BRANCH, 1'b1);
    check("br_taken", 32'({rf_we, pc_we, pc_sel}), 32'b0101);
    cyc();
    run_to_wb(OPCODE_BRANCH, 1'b0);
    check("br_ntaken", 32'({rf_we, pc_we, pc_sel}), 32'b0100);
    cyc();
    branch_cond = 1'b0;
    run_to_wb(OPCODE_JALR, 1'b0);
    check("jalr", 32'({rf_we, pc_we, pc_sel}), 32'b1110);
    cyc();
    run_to_wb(OPCODE_JAL, 1'b0);
    check("jal", 32'({rf_we, pc_we, pc_sel}), 32'b1101);
    cyc();
    check("jal_pcsel_out", 32'(pc_sel), 32'd0);

    // STORE with immediate accept
    fetch_op(OPCODE_STORE);
    cyc(); cyc();
    bus.lsu_req_ready = 1'b1;
    settle();
    check("st_req", 32'({bus.lsu_req_valid, bus.lsu_req_wen}), 32'b11);
    cyc();
    bus.lsu_req_ready = 1'b0;
    bus.lsu_resp_valid = 1'b1;
    cyc();
    bus.lsu_resp_valid = 1'b0;
    check("st_wb", 32'({state, rf_we, pc_we}), 32'({3'd7, 2'b01}));
    cyc();

    // Asynchronous reset in the middle of a MEM handshake
    fetch_op(OPCODE_LOAD);
    cyc(); cyc();
    check("mr_mem_vld", 32'(bus.lsu_req_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_vld_drop", 32'(bus.lsu_req_valid), 32'd0);
    check("mr_idle", 32'(state), 32'd0);
    do_reset();

    // MWAIT with no response
    fetch_op(OPCODE_LOAD);
    cyc(); cyc();
    bus.lsu_req_ready = 1'b1;
    cyc();
    bus.lsu_req_ready = 1'b0;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      check("to_wait", 32'({state, timeout}), 32'({3'd6, 1'b0}));
      cyc();
    end
    check("to_flag", 32'({halt, timeout}), 32'b11);
    check("to_state", 32'(state), 32'd0);
`else
    for (int i = 0; i < 20; i++) cyc();
    check("nto_stay", 32'({state, timeout, halt}), 32'({3'd6, 2'b00}));
`endif
    do_reset();

    // EBREAK halts without illegal; fetch never requested again
    fetch_op(OPCODE_SYSTEM);
    cyc();
    check("eb_halt", 32'({halt, illegal, state}), 32'({2'b10, 3'd0}));
    bus.ifu_req_ready = 1'b1; bus.ifu_resp_valid = 1'b1;
    bus.lsu_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("eb_no_fetch", 32'({bus.ifu_req_valid, ir_we, rf_we, pc_we, bus.lsu_req_valid}), 32'd0);
      cyc();
    end
    check("eb_sticky", 32'(halt), 32'd1);
    do_reset();

    // Unknown opcode halts with illegal
    fetch_op(7'b0000000);
    cyc();
    check("il_halt", 32'({halt, illegal}), 32'b11);
    cyc();
    check("il_sticky", 32'(illegal), 32'd1);
    do_reset();
    check("il_cleared", 32'(illegal), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
